dither_sequencer: RTL
=====================

DITHER_SEQUENCER -- requirements
Module: dither_sequencer

Parameters
REQ-001 SHALL have parameter H_SIZE, default 607, pixels per line (>=4).
REQ-002 SHALL have parameter V_SIZE, default 455, lines per frame (>=1).
REQ-003 SHALL have parameter LINE_GAP, default 1, idle cycles between lines (>=1).
REQ-004 SHALL have parameter ADDR_W, default 19, frame-buffer address width; H_SIZE*V_SIZE SHALL fit in ADDR_W bits.

Interface
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  frame request, sampled only in IDLE.
REQ-008 abort  in  1  cancel current frame.
REQ-009 rd_addr  out  ADDR_W  source frame-buffer read address.
REQ-010 rd_en  out  1  read strobe; memory returns data on the next cycle.
REQ-011 rd_data  in  18  source pixel, {R6,G6,B6}.
REQ-012 raw_rgb  out  18  pixel to dithering datapath, combinational copy of rd_data.
REQ-013 synch_pulse  out  1  start-of-line pulse to dithering datapath.
REQ-014 dith_clear  out  1  one-cycle active-high clear to dithering datapath.
REQ-015 out_rgb  in  12  dithered pixel from datapath, {R4,G4,B4}.
REQ-016 wr_addr  out  ADDR_W  destination frame-buffer write address.
REQ-017 wr_en  out  1  write strobe.
REQ-018 wr_data  out  12  equals out_rgb.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 frame_done  out  1  one-cycle pulse after last pixel written.
REQ-021 line_count  out  10  index of line being read.

Function
REQ-022 States: IDLE, CLEAR, SYNC, STREAM, DRAIN, GAP, DONE.
REQ-023 IDLE->CLEAR when start=1; CLEAR lasts 1 cycle with dith_clear=1, line_count=0, then SYNC.
REQ-024 SYNC lasts 1 cycle: synch_pulse=1, rd_en=1, reads pixel 0 of line_count.
REQ-025 STREAM lasts H_SIZE-1 cycles: rd_en=1, reads pixels 1..H_SIZE-1 in order.
REQ-026 rd_addr = line_count*H_SIZE + pixel index; address produced by incrementing counter, no multiplier.
REQ-027 Write pipeline: rd_en delayed 2 cycles gives wr_en; read address delayed 2 cycles gives wr_addr.
REQ-028 Pixel i read at cycle S+i (S = SYNC cycle) SHALL be written at cycle S+2+i.
REQ-029 DRAIN lasts 2 cycles with rd_en=0, covering writes of pixels H_SIZE-2 and H_SIZE-1.
REQ-030 GAP lasts LINE_GAP cycles.
REQ-031 After GAP: if line_count=V_SIZE-1, go to DONE; otherwise increment line_count and go to SYNC.
REQ-032 Consecutive SYNC cycles SHALL be spaced exactly H_SIZE+2+LINE_GAP cycles apart.
REQ-033 DONE lasts 1 cycle with frame_done=1, then IDLE.
REQ-034 start while busy=1 SHALL be ignored and not queued.
REQ-035 abort=1 in any non-IDLE state: next cycle is IDLE, dith_clear=1 for that one cycle.
REQ-036 On abort, rd_en, wr_en and the write pipeline SHALL clear immediately; frame_done not pulsed.
REQ-037 abort has priority over start and all transitions; abort in IDLE has no effect.
REQ-038 Last pixel of the frame (H_SIZE*V_SIZE-1) SHALL be written; the address counter does not wrap within a frame.

Reset
REQ-039 While reset=0: state=IDLE; rd_en, wr_en, synch_pulse, frame_done, busy all 0; dith_clear=1.
REQ-040 While reset=0: rd_addr, wr_addr, line_count all 0; write pipeline cleared.
REQ-041 Reset asserted mid-frame SHALL abort without frame_done; after release, stays in IDLE until start.

Verification (H_SIZE=4, V_SIZE=2, LINE_GAP=1, memory holds address value in rd_data)
REQ-042 Start pulse at cycle 0 -> CLEAR at 1, SYNC at 2 and 9, DONE/frame_done at 16, busy 1..16.
REQ-043 Full frame -> wr_addr sequence 0..7, one write per cycle at cycles 4-7 and 11-14, no duplicates, no gaps.
REQ-044 Model datapath (out_rgb = registered raw_rgb[17:14],[11:8],[5:2]) -> wr_data matches pixel at wr_addr.
REQ-045 abort at cycle 6 -> IDLE at 7, dith_clear=1 at 7, no writes from 7 on, no frame_done; next start runs a clean frame.
REQ-046 start held high through a frame -> second frame's CLEAR exactly 1 cycle after the IDLE following DONE; start pulses during busy ignored.
REQ-047 reset low at cycle 10 -> all outputs at reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/dither_sequencer.sv
// Frame sequencer for a pixel dithering datapath: reads a source frame line by line,
// drives the datapath and writes the dithered result two cycles behind each read.
module dither_sequencer #(
  parameter int H_SIZE   = 607,
  parameter int V_SIZE   = 455,
  parameter int LINE_GAP = 1,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [17:0]       rd_data,
  output logic [17:0]       raw_rgb,
  output logic              synch_pulse,
  output logic              dith_clear,
  input  logic [11:0]       out_rgb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic [11:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [9:0]        line_count
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_SYNC   = 3'd2;
  localparam logic [2:0] ST_STREAM = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  // One shared phase counter times STREAM, DRAIN and GAP; size it for the longest.
  localparam int CNT_MAX = (H_SIZE > LINE_GAP) ? H_SIZE : LINE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(H_SIZE - 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(LINE_GAP - 1);
  localparam logic [9:0]       LAST_LINE   = 10'(V_SIZE - 1);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [9:0]        r_line;
  logic [ADDR_W-1:0] r_addr;
  logic              r_clr_pend;
  logic              r_en_d1;
  logic              r_en_d2;
  logic [ADDR_W-1:0] r_addr_d1;
  logic [ADDR_W-1:0] r_addr_d2;

  logic w_rd_en;
  logic w_abort;

  assign w_rd_en = (r_state == ST_SYNC) || (r_state == ST_STREAM);
  assign w_abort = abort && (r_state != ST_IDLE);

  // The read address is a running counter: it steps once per read, so the start of
  // line n lands on n*H_SIZE without a multiplier.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: all state here uses non-blocking assignment so every register samples
    // the pre-edge values; blocking would let later statements see updated state.
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_line     <= '0;
      r_addr     <= '0;
      r_clr_pend <= 1'b1;
    end else if (w_abort) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_clr_pend <= 1'b1;
    end else begin
      r_clr_pend <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_CLEAR;
            r_line  <= '0;
            r_addr  <= '0;
          end
        end
        ST_CLEAR: begin
          r_state <= ST_SYNC;
          r_cnt   <= '0;
        end
        ST_SYNC: begin
          r_state <= ST_STREAM;
          r_addr  <= r_addr + ADDR_W'(1);
          r_cnt   <= '0;
        end
        ST_STREAM: begin
          r_addr <= r_addr + ADDR_W'(1);
          if (r_cnt == STREAM_LAST) begin
            r_state <= ST_DRAIN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (r_cnt == DRAIN_LAST) begin
            r_state <= ST_GAP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt <= '0;
            if (r_line == LAST_LINE) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_SYNC;
              r_line  <= r_line + 10'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Two-stage write pipeline: one cycle for the memory read, one for the datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en_d1   <= 1'b0;
      r_en_d2   <= 1'b0;
      r_addr_d1 <= '0;
      r_addr_d2 <= '0;
    end else if (w_abort) begin
      r_en_d1   <= 1'b0;
      r_en_d2   <= 1'b0;
      r_addr_d1 <= '0;
      r_addr_d2 <= '0;
    end else begin
      r_en_d1   <= w_rd_en;
      r_en_d2   <= r_en_d1;
      r_addr_d1 <= r_addr;
      r_addr_d2 <= r_addr_d1;
    end
  end

  assign rd_en       = w_rd_en;
  assign rd_addr     = r_addr;
  assign raw_rgb     = rd_data;
  assign synch_pulse = (r_state == ST_SYNC);
  // The clear is held through reset and pulsed once after an abort.
  assign dith_clear  = (r_state == ST_CLEAR) || r_clr_pend;
  assign wr_en       = r_en_d2;
  assign wr_addr     = r_addr_d2;
  assign wr_data     = out_rgb;
  assign busy        = (r_state != ST_IDLE);
  assign frame_done  = (r_state == ST_DONE);
  assign line_count  = r_line;

endmodule
